// File: rtl/btn_press_emulator.sv
// Push-button stimulus source: on start, drives btn_raw through press chatter, a stable
// hold, release chatter and a settle period, then pulses done for one cycle.
module btn_press_emulator #(
    parameter int unsigned DIV      = 8,
    parameter int unsigned N        = 4,
    parameter int unsigned CH_EDGES = 3,
    parameter int unsigned CH_HALF  = 4,
    parameter int unsigned SETTLE   = N + 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] hold_samples,
    output logic       btn_raw,
    output logic       busy,
    output logic       done
);

    localparam int unsigned HOLD_MAX   = 255 * DIV;
    localparam int unsigned SETTLE_LEN = SETTLE * DIV;
    localparam int unsigned CNT_MAX0   = (HOLD_MAX > SETTLE_LEN) ? HOLD_MAX : SETTLE_LEN;
    localparam int unsigned CNT_MAX    = (CNT_MAX0 > CH_HALF) ? CNT_MAX0 : CH_HALF;
    localparam int unsigned CW         = $clog2(CNT_MAX + 1);
    localparam int unsigned EW         = $clog2(CH_EDGES + 1);

    localparam logic [CW-1:0] HALF_LAST   = CW'(CH_HALF - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'((SETTLE_LEN == 0) ? 0 : SETTLE_LEN - 1);
    localparam logic [EW-1:0] EDGE_LAST   = EW'(CH_EDGES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StPChat,
        StHold,
        StRChat,
        StSettle,
        StDone
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [EW-1:0] edge_q;
    logic [7:0]    hold_q;
    logic [CW-1:0] hold_last;

    // Only consulted in StHold, where hold_q is known to be non-zero.
    assign hold_last = CW'(hold_q) * CW'(DIV) - CW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            edge_q  <= '0;
            hold_q  <= '0;
            btn_raw <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        hold_q  <= hold_samples;
                        cnt_q   <= '0;
                        edge_q  <= '0;
                        busy    <= 1'b1;
                        state_q <= StPChat;
                    end
                end
                StPChat: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q   <= '0;
                        btn_raw <= ~btn_raw;
                        if (edge_q == EDGE_LAST) begin
                            edge_q  <= '0;
                            state_q <= (hold_q == 8'd0) ? StRChat : StHold;
                        end else begin
                            edge_q <= edge_q + EW'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                StHold: begin
                    if (cnt_q == hold_last) begin
                        cnt_q   <= '0;
                        state_q <= StRChat;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                StRChat: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q   <= '0;
                        btn_raw <= ~btn_raw;
                        if (edge_q == EDGE_LAST) begin
                            edge_q <= '0;
                            if (SETTLE_LEN == 0) begin
                                done    <= 1'b1;
                                state_q <= StDone;
                            end else begin
                                state_q <= StSettle;
                            end
                        end else begin
                            edge_q <= edge_q + EW'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                StSettle: begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_q   <= '0;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_btn_press_emulator.sv
// Scoreboard bench for btn_press_emulator: the driver queues expected btn_raw edges and
// done pulses with their cycle numbers; a negedge monitor pops and compares observed events.
module tb_btn_press_emulator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] hold_samples = 8'd0;
    logic       btn_raw;
    logic       busy;
    logic       done;

    btn_press_emulator dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .hold_samples (hold_samples),
        .btn_raw      (btn_raw),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;  // 0: btn_raw edge, 1: done pulse
        int val;
        int t;
    } ev_t;

    ev_t  q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    logic prev_btn = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic observe(input int kind, input int val);
        ev_t e;
        n_checks++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d value %0d at cycle %0d, required none",
                     kind, val, cyc);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.val != val || e.t != cyc) begin
                n_fail++;
                $display("FAIL event_order: got kind %0d value %0d at cycle %0d, required kind %0d value %0d at cycle %0d",
                         kind, val, cyc, e.kind, e.val, e.t);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (btn_raw !== prev_btn) observe(0, int'(btn_raw));
            if (done === 1'b1) begin
                observe(1, 1);
                check("busy_in_done", {31'd0, busy}, 32'd1);
            end
        end
        prev_btn = btn_raw;
    end

    // rel_rel: cycles from accept to the end of the hold; rel_done: accept to done
    task automatic expect_seq(input int acc, input int rel_rel, input int rel_done);
        q.push_back('{0, 1, acc + 4});
        q.push_back('{0, 0, acc + 8});
        q.push_back('{0, 1, acc + 12});
        q.push_back('{0, 0, acc + rel_rel + 4});
        q.push_back('{0, 1, acc + rel_rel + 8});
        q.push_back('{0, 0, acc + rel_rel + 12});
        q.push_back('{1, 1, acc + rel_done});
    endtask

    task automatic issue_start(input logic [7:0] hold, output int acc);
        @(negedge clk);
        hold_samples = hold;
        start = 1'b1;
        acc = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (q.size() == 0) break;
        end
        check("seq_complete_pending", q.size(), 32'd0);
        q.delete();
        @(negedge clk);
        @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_btn_raw", {31'd0, btn_raw}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;

        // Reset held for 5 clocks with start low
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_btn_raw", {31'd0, btn_raw}, 32'd0);
            check("rst_busy", {31'd0, busy}, 32'd0);
            check("rst_done", {31'd0, done}, 32'd0);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // hold=6; hold_samples changed after accept must not matter
        issue_start(8'd6, acc);
        expect_seq(acc, 60, 120);
        hold_samples = 8'hFF;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        wait_done(200);

        // hold=2
        issue_start(8'd2, acc);
        expect_seq(acc, 28, 88);
        wait_done(200);

        // hold=6 with a second start at +30 that must be ignored
        issue_start(8'd6, acc);
        expect_seq(acc, 60, 120);
        while (cyc < acc + 29) @(negedge clk);
        hold_samples = 8'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(200);

        // Async reset in HOLD aborts the sequence
        issue_start(8'd6, acc);
        expect_seq(acc, 60, 120);
        while (cyc < acc + 30) @(negedge clk);
        #2;
        q.delete();
        rst = 1'b1;
        #1;
        check("abort_btn_raw", {31'd0, btn_raw}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("abort_stays_idle", {31'd0, busy}, 32'd0);
        issue_start(8'd6, acc);
        expect_seq(acc, 60, 120);
        wait_done(200);

        // hold=0 plus a start issued in the DONE cycle
        issue_start(8'd0, acc);
        expect_seq(acc, 12, 72);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done === 1'b1) break;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(20);
        repeat (20) @(negedge clk);
        check("start_in_done_ignored", {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
